// File: rtl/fib_reverse_walker_pkg.sv
// Shared definitions for the Fibonacci reverse walker: state encoding,
// seed pair and step-counter saturation helper.
package fib_reverse_walker_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned IDX_W_DEF = 5;

  localparam int unsigned SEED_A = 0;
  localparam int unsigned SEED_B = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // All-ones value of a w-bit step counter; reaching it aborts the walk.
  function automatic int unsigned idx_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/fib_reverse_walker_if.sv
// Request/result bundle between a client and the Fibonacci reverse walker.
interface fib_reverse_walker_if
  import fib_reverse_walker_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             valid;
  logic [IDX_W-1:0] index;

  modport master (
    output start, a, b,
    input  busy, done, valid, index
  );

  modport slave (
    input  start, a, b,
    output busy, done, valid, index
  );

endinterface

// File: rtl/fib_reverse_walker_rsub_ripple.sv
// WIDTH-bit ripple subtractor, diff = x - y, built from full-subtractor cells.
module rsub_ripple #(
  parameter int unsigned WIDTH = 16
) (
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y
);

  logic [WIDTH:0] bw;

  assign bw[0] = 1'b0;

  // Borrow ripples from LSB upward; final borrow set means y > x.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign diff[i]  = x[i] ^ y[i] ^ bw[i];
    assign bw[i+1]  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw[i]);
  end

  assign borrow = bw[WIDTH];

endmodule

// File: rtl/fib_reverse_walker.sv
// Walks a candidate Fibonacci pair back to the seed (0,1) and reports
// whether it lies on the standard sequence together with the index of B.
module fib_reverse_walker
  import fib_reverse_walker_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fib_reverse_walker_if.slave  bus
);

  localparam logic [IDX_W-1:0] STEPS_SAT = IDX_W'(idx_sat(IDX_W));
  localparam logic [WIDTH-1:0] SEED_A_W  = WIDTH'(SEED_A);
  localparam logic [WIDTH-1:0] SEED_B_W  = WIDTH'(SEED_B);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] steps_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic [IDX_W-1:0] index_q;

  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             at_seed;
  logic             bad_pair;

  // b - a; borrow flags a > b so a wrapped step is never committed.
  rsub_ripple #(.WIDTH(WIDTH)) u_rsub (
    .diff   (diff),
    .borrow (borrow),
    .x      (b_q),
    .y      (a_q)
  );

  assign at_seed  = (a_q == SEED_A_W) && (b_q == SEED_B_W);
  assign bad_pair = (b_q == '0) || (a_q == '0) || borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            steps_q <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (at_seed) begin
            valid_q <= 1'b1;
            index_q <= steps_q + IDX_W'(1);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else if (bad_pair || (steps_q == STEPS_SAT)) begin
            valid_q <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            a_q     <= diff;
            b_q     <= a_q;
            steps_q <= steps_q + IDX_W'(1);
          end
        end
        ST_FIN: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
  assign bus.index = index_q;

endmodule

// File: tb/tb_fib_reverse_walker.sv
// Directed and randomized bench for fib_reverse_walker against a
// Fibonacci-table reference model.
module tb_fib_reverse_walker;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned NMAX  = 24;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  int unsigned fib [0:NMAX];

  fib_reverse_walker_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  fib_reverse_walker #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Valid/index from a table of the sequence; invalid latency from the
  // number of backward steps taken before a rule rejects the pair.
  task automatic model(input int unsigned ia, input int unsigned ib,
                       output bit v, output int unsigned idx, output int unsigned lat);
    int unsigned x, y, t;
    v = 1'b0; idx = 0; lat = 0;
    for (int n = 1; n <= int'(NMAX); n++)
      if (fib[n-1] == ia && fib[n] == ib) begin v = 1'b1; idx = n; end
    if (v) begin
      lat = idx;
    end else begin
      x = ia; y = ib;
      for (int k = 0; k <= 31; k++) begin
        if (y == 0 || x == 0 || x > y || k == 31) begin lat = k + 1; break; end
        t = y - x; y = x; x = t;
      end
    end
  endtask

  // One request; poke>0 re-pulses Start (0,1) so it is sampled at edge E0+poke.
  task automatic run_walk(input logic [15:0] ia, input logic [15:0] ib,
                          input bit ev, input int unsigned eidx, input int unsigned elat,
                          input int poke, input string tag);
    int lat_obs;
    int busy_cnt;
    lat_obs  = 0;
    busy_cnt = 0;
    bus.start = 1'b1; bus.a = ia; bus.b = ib;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    if (bus.busy) busy_cnt++;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat_obs = cyc; break; end
      if (bus.busy) busy_cnt++;
      if (cyc == poke - 1) begin
        bus.start = 1'b1; bus.a = 16'd0; bus.b = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, "_lat"},   32'(lat_obs),   32'(elat));
    check({tag, "_valid"}, 32'(bus.valid), 32'(ev));
    check({tag, "_index"}, 32'(bus.index), eidx);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(elat));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold_index"}, 32'(bus.index), eidx);
  endtask

  initial begin
    bit          mv;
    int unsigned midx, mlat, n;
    logic [15:0] ra, rb;

    checks = 0;
    errors = 0;
    fib[0] = 0; fib[1] = 1;
    for (int i = 2; i <= int'(NMAX); i++) fib[i] = fib[i-1] + fib[i-2];

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_index", 32'(bus.index), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_walk(16'd0, 16'd1, 1'b1, 1, 1, 0, "seed");
    run_walk(16'd5, 16'd8, 1'b1, 6, 6, 0, "p5_8");
    repeat (3) @(posedge clk);
    #1;
    check("p5_8_held_valid", 32'(bus.valid), 32'd1);
    check("p5_8_held_index", 32'(bus.index), 32'd6);

    run_walk(16'd28657, 16'd46368, 1'b1, 24, 24, 0, "max");
    run_walk(16'd8, 16'd5, 1'b0, 0, 1, 0, "rev8_5");
    run_walk(16'd3, 16'd7, 1'b0, 0, 2, 0, "p3_7");
    run_walk(16'd0, 16'd0, 1'b0, 0, 1, 0, "zero");
    run_walk(16'd2, 16'd2, 1'b0, 0, 2, 0, "p2_2");
    run_walk(16'd1, 16'd1, 1'b1, 2, 2, 0, "p1_1");
    run_walk(16'd5, 16'd8, 1'b1, 6, 6, 2, "ignored");

    // Reset in the middle of a walk must kill it without a Done.
    bus.start = 1'b1; bus.a = 16'd5; bus.b = 16'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy",  32'(bus.busy),  32'd0);
    check("midrst_done",  32'(bus.done),  32'd0);
    check("midrst_valid", 32'(bus.valid), 32'd0);
    check("midrst_index", 32'(bus.index), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_idle_done", 32'(bus.done), 32'd0);
    run_walk(16'd1, 16'd2, 1'b1, 3, 3, 0, "postrst");

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          n  = $urandom_range(1, NMAX);
          ra = 16'(fib[n-1]); rb = 16'(fib[n]);
        end
        1: begin
          ra = 16'($urandom); rb = 16'($urandom);
        end
        default: begin
          n  = $urandom_range(2, NMAX);
          ra = 16'(fib[n-1] + $urandom_range(1, 3));
          rb = 16'(fib[n]);
        end
      endcase
      model(32'(ra), 32'(rb), mv, midx, mlat);
      run_walk(ra, rb, mv, midx, mlat, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_reverse_walker.md
Name: fib_reverse_walker

Overview:
- Inverse of the Fibonacci generator datapath. It accepts a candidate consecutive pair (A = F(n-1), B = F(n)).
- Each cycle it walks the sequence backwards by subtraction, (a,b) <- (b-a, a), until it reaches the seed pair (0,1) or detects an invalid pair.
- Reports whether the pair lies on the standard sequence (F0=0, F1=1) and the index n of B.
- Sits beside the generator as its checker/decoder. It shares the ripple bit-cell style, with subtractor cells in place of full-adder cells.

Parameters:
- WIDTH, 16, bit width of A, B and internal pair registers
- IDX_W, 5, width of Index and step counter; walk aborts as invalid when the counter saturates at 2^IDX_W-1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only in IDLE
- A  input  WIDTH  candidate F(n-1)
- B  input  WIDTH  candidate F(n)
- Busy  output  1  high while walking
- Done  output  1  one-cycle pulse when result is final
- Valid  output  1  result: pair is on the sequence; held until next Start
- Index  output  IDX_W  n of B when Valid=1, else 0; held until next Start

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State=IDLE; Busy=0, Done=0, Valid=0, Index=0.
  - Internal a, b and steps cleared.
  - Reset mid-walk aborts the walk immediately; no Done is produced.
- States: IDLE, WALK, FIN.
- IDLE:
  - At an edge E0 with Start=1: load a<=A, b<=B, steps<=0; clear Valid and Index; Busy<=1; go to WALK.
  - Start=0: stay in IDLE.
- WALK evaluates the current (a,b) each cycle, with checks in this priority order:
  - 1) a==0 and b==1 -> success: Valid<=1, Index<=steps+1, go to FIN.
  - 2) b==0, or a==0 (with b!=1), or a>b (subtractor borrow out = 1) -> invalid: Valid<=0, Index<=0, go to FIN.
  - 3) steps==2^IDX_W-1 -> invalid (saturation guard), go to FIN.
  - 4) Otherwise: a<=b-a, b<=a, steps<=steps+1, stay in WALK.
- Transition into FIN: Done<=1 and Busy<=0 are registered on the same edge. Done is high for exactly one cycle; FIN then returns to IDLE with Done<=0.
- Latency:
  - Valid pair with index n: Done is high in the cycle following edge E0+n.
  - Invalid pair detected after k steps: Done follows edge E0+k+1.
- Start while Busy=1 or in FIN is ignored and not queued.
- Start may be asserted in the cycle immediately after FIN (IDLE) with no bubble.
- Arithmetic:
  - b-a is computed as b + ~a + 1 in WIDTH bits.
  - Borrow = inverted carry-out; it is used for the a>b check.
  - No wrap-around is ever committed, because a>b is rejected before any step.
- A==B==1 is valid with n=2. A==B>1 is invalid: it reaches a==0 with b!=1.
- Max representable result for WIDTH=16 is n=24 (A=28657, B=46368).

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WALK=2'd1, FIN=2'd2), the seed constants (SEED_A=0, SEED_B=1), and the index saturation constant.
- One sub-module, rsub_ripple: a WIDTH-bit ripple subtractor built from per-bit full-subtractor cells.
  - Ports: Diff, Borrow, X, Y.
  - Computes X-Y. Borrow=1 when Y>X.

Test Plan:
- Reset, then Start with A=0, B=1 -> Done after E0+1, Valid=1, Index=1; Busy high for exactly 1 cycle.
- A=5, B=8 -> walks (3,5),(2,3),(1,2),(1,1),(0,1); Done after E0+6, Valid=1, Index=6; Index and Valid held until next Start.
- A=28657, B=46368 -> Done after E0+24, Valid=1, Index=24. Then Start A=8, B=5 immediately in IDLE -> Done after E0+1, Valid=0, Index=0.
- A=3, B=7 -> (4,3) then a>b; Done after E0+2, Valid=0, Index=0. Also A=0, B=0 -> invalid after E0+1. Also A=2, B=2 -> invalid after E0+2.
- During the A=5, B=8 walk, pulse Start with A=0, B=1 at E0+2 -> ignored; result is still Index=6. Then a second walk with rst_n low at E0+3 -> all outputs 0 asynchronously, no Done; after release, a new Start works normally.
